// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Also used by the decode side for bubble insertion.
package fetch_unit_pkg;

  localparam int XLEN               = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam word_t INSTR_NOP        = 32'h0000_0013;
  localparam word_t ADDR_ALIGN_MASK  = ~XLEN'(3);
  localparam word_t INSTR_BYTES      = XLEN'(4);

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  function automatic word_t align_pc(input word_t pc);
    return pc & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect from the core, instruction-memory request/response,
// and the instruction delivery handshake toward decode.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  redirect_valid;
  word_t redirect_pc;

  logic  mem_req_valid;
  word_t mem_req_addr;
  logic  mem_req_ready;
  logic  mem_rsp_valid;
  word_t mem_rsp_data;

  logic  inst_valid;
  word_t inst_data;
  word_t inst_pc;
  logic  inst_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Registered prefetch FIFO of {pc, inst} entries; flush wins over push,
// and push+pop in one cycle is accepted even when full.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked only by
  // count and the pointers, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-based request throttling,
// stale-response dropping after redirects, and prefetch buffering.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC   = DEFAULT_RESET_PC,
  parameter int    FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  word_t          fetch_pc;
  word_t          rsp_pc;
  word_t          redirect_target;
  cnt_t           in_flight;
  cnt_t           in_flight_next;
  cnt_t           drop_cnt;
  cnt_t           fifo_count;
  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           rsp_fire;
  logic           rsp_drop;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  fetch_entry_t   push_entry;
  fetch_entry_t   head;

  assign redirect_target = align_pc(bus.redirect_pc);

  // Every live request owns a FIFO slot, so responses never need back-pressure.
  assign credit_used = {1'b0, fifo_count} + {1'b0, in_flight} - {1'b0, drop_cnt};

  assign bus.mem_req_valid = !reset && !bus.redirect_valid &&
                             (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign bus.mem_req_addr  = fetch_pc;
  assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    rsp_fire = bus.mem_rsp_valid && !reset;
    rsp_drop = 1'b0;
    push     = 1'b0;
    if (rsp_fire) begin
      if (drop_cnt != '0)            rsp_drop = 1'b1;
      else if (!bus.redirect_valid)  push     = 1'b1;
    end
    in_flight_next = in_flight + cnt_t'(req_fire) - cnt_t'(rsp_fire);
  end

  assign push_entry = '{pc: rsp_pc, inst: bus.mem_rsp_data};
  assign pop        = bus.inst_valid && bus.inst_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.inst_valid = !reset && !fifo_empty;
  assign bus.inst_data  = head.inst;
  assign bus.inst_pc    = head.pc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight_next;
      if (bus.redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= in_flight_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + INSTR_BYTES;
        if (push)     rsp_pc   <= rsp_pc + INSTR_BYTES;
        if (rsp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
      end
    end
  end

  rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.mem_rsp_valid |-> (in_flight != '0));

  push_has_room: assert property (@(posedge clk) disable iff (reset)
    push |-> !fifo_full);

endmodule
